// File: rtl/scan_engine_if.sv
// scan_engine_if: start/done handshake plus the host array port of the
// scan engine, bundled so the controller and the kernel share one bundle.
interface scan_engine_if #(
   parameter int DW = 64,
   parameter int AW = 10
);
   logic          r_enable;
   logic [AW-1:0] init_i;
   logic [AW:0]   init_len;
   logic [DW-1:0] init_acc;
   logic [1:0]    mode;
   logic          controlArr;
   logic          controlArrWEnable;
   logic [AW-1:0] controlArrAddr;
   logic [DW-1:0] controlArrWData;
   logic [DW-1:0] controlArrRData;
   logic          w_enable;
   logic [DW-1:0] result;
   logic          trunc;

   modport master (
      output r_enable, init_i, init_len, init_acc, mode,
      output controlArr, controlArrWEnable, controlArrAddr, controlArrWData,
      input  controlArrRData, w_enable, result, trunc
   );

   modport slave (
      input  r_enable, init_i, init_len, init_acc, mode,
      input  controlArr, controlArrWEnable, controlArrAddr, controlArrWData,
      output controlArrRData, w_enable, result, trunc
   );
endinterface

// File: rtl/scan_engine.sv
// scan_engine: in-place scan/reduce kernel over a private single-port array.
// Each element takes three cycles (read, accumulate, write-back). The host
// port owns the array whenever controlArr is high and the run freezes.
module scan_engine #(
   parameter int DW    = 64,
   parameter int AW    = 10,
   parameter int DEPTH = 1000,
   parameter int SAT   = 0
) (
   input logic          clk,
   input logic          rst_n,
   scan_engine_if.slave bus
);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_ACC  = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic [DW-1:0] acc_r, acc_s, wdat_r, wdat_s, result_r, result_s;
   logic [AW-1:0] idx_r, idx_s;
   logic [AW:0]   cnt_r, cnt_s, avail_s, load_cnt_s;
   logic [1:0]    mode_r, mode_s;
   logic          clip_r, clip_s, load_clip_s;
   logic          w_en_r, w_en_s, trunc_r, trunc_s;
   logic          eng_we_s, mem_we_s, mem_ok_s;
   logic [AW-1:0] mem_addr_s;
   logic [DW-1:0] mem_wdata_s, rdata_r;
   logic [DW-1:0] mem_r [0:DEPTH-1];

   // Signed add evaluated one bit wider; clamps on overflow when SAT is set.
   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] s;
      s = {a[DW-1], a} + {b[DW-1], b};
      if ((SAT != 0) && (s[DW] != s[DW-1])) begin
         if (s[DW]) sat_add = {1'b1, {(DW-1){1'b0}}};
         else       sat_add = {1'b0, {(DW-1){1'b1}}};
      end else begin
         sat_add = s[DW-1:0];
      end
   endfunction

   // Start-of-run bookkeeping: elements left before the array end and clipping.
   always_comb begin
      if ({1'b0, bus.init_i} < DEPTH_L) avail_s = DEPTH_L - {1'b0, bus.init_i};
      else                              avail_s = {(AW+1){1'b0}};
      load_cnt_s  = (bus.init_len < avail_s) ? bus.init_len : avail_s;
      load_clip_s = (bus.init_len > avail_s);
   end

   // Next state and datapath: restart has priority, then host stall, then the run.
   always_comb begin
      state_s  = state_r;
      acc_s    = acc_r;
      wdat_s   = wdat_r;
      result_s = result_r;
      idx_s    = idx_r;
      cnt_s    = cnt_r;
      mode_s   = mode_r;
      clip_s   = clip_r;
      w_en_s   = w_en_r;
      trunc_s  = trunc_r;
      eng_we_s = 1'b0;
      if (bus.r_enable) begin
         idx_s   = bus.init_i;
         acc_s   = bus.init_acc;
         mode_s  = bus.mode;
         cnt_s   = load_cnt_s;
         clip_s  = load_clip_s;
         w_en_s  = 1'b0;
         trunc_s = 1'b0;
         state_s = (load_cnt_s != {(AW+1){1'b0}}) ? ST_RD : ST_DONE;
      end else if (bus.controlArr) begin
         // The host may have clobbered the read data, so ACC replays its read.
         if (state_r == ST_ACC) state_s = ST_RD;
         else                   state_s = state_r;
      end else begin
         case (state_r)
            ST_RD: begin
               state_s = ST_ACC;
            end
            ST_ACC: begin
               case (mode_r)
                  2'd0: begin
                     acc_s  = sat_add(acc_r, rdata_r);
                     wdat_s = acc_s;
                  end
                  2'd1: begin
                     wdat_s = acc_r;
                     acc_s  = sat_add(acc_r, rdata_r);
                  end
                  2'd2: begin
                     acc_s = sat_add(acc_r, rdata_r);
                  end
                  default: begin
                     acc_s  = ($signed(rdata_r) > $signed(acc_r)) ? rdata_r : acc_r;
                     wdat_s = acc_s;
                  end
               endcase
               state_s = ST_WR;
            end
            ST_WR: begin
               eng_we_s = (mode_r != 2'd2);
               idx_s    = idx_r + AW'(1);
               cnt_s    = cnt_r - (AW+1)'(1);
               state_s  = (cnt_r > (AW+1)'(1)) ? ST_RD : ST_DONE;
            end
            ST_DONE: begin
               result_s = acc_r;
               w_en_s   = 1'b1;
               trunc_s  = clip_r;
               state_s  = ST_IDLE;
            end
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Array port mux: the host wins outright; the engine addresses idx otherwise.
   always_comb begin
      if (bus.controlArr) begin
         mem_we_s    = bus.controlArrWEnable;
         mem_addr_s  = bus.controlArrAddr;
         mem_wdata_s = bus.controlArrWData;
      end else begin
         mem_we_s    = eng_we_s;
         mem_addr_s  = idx_r;
         mem_wdata_s = wdat_r;
      end
      mem_ok_s = ({1'b0, mem_addr_s} < DEPTH_L);
   end

   // Single-port array with registered read; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s && mem_ok_s) mem_r[mem_addr_s] <= mem_wdata_s;
      if (mem_ok_s) rdata_r <= mem_r[mem_addr_s];
      else          rdata_r <= {DW{1'b0}};
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r    <= {DW{1'b0}};
         wdat_r   <= {DW{1'b0}};
         result_r <= {DW{1'b0}};
         idx_r    <= {AW{1'b0}};
         cnt_r    <= {(AW+1){1'b0}};
         mode_r   <= 2'd0;
         clip_r   <= 1'b0;
         w_en_r   <= 1'b0;
         trunc_r  <= 1'b0;
      end else begin
         acc_r    <= acc_s;
         wdat_r   <= wdat_s;
         result_r <= result_s;
         idx_r    <= idx_s;
         cnt_r    <= cnt_s;
         mode_r   <= mode_s;
         clip_r   <= clip_s;
         w_en_r   <= w_en_s;
         trunc_r  <= trunc_s;
      end
   end

   assign bus.controlArrRData = rdata_r;
   assign bus.w_enable        = w_en_r;
   assign bus.result          = result_r;
   assign bus.trunc           = trunc_r;
endmodule

// File: tb/tb_scan_engine.sv
// tb_scan_engine: drives a wrapping (SAT=0) and a saturating (SAT=1) engine
// with identical stimulus and checks both against a reference model.
module tb_scan_engine;
   localparam int DW = 64;
   localparam int AW = 10;
   localparam int DEPTH = 1000;
   localparam int BIG = 1 << 30;
   localparam logic signed [64:0] MAXV = 65'sh0_7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [64:0] MINV = -65'sh0_8000_0000_0000_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          r_enable;
   logic [AW-1:0] init_i;
   logic [AW:0]   init_len;
   logic [DW-1:0] init_acc;
   logic [1:0]    mode;
   logic          host_en, host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;

   int n_checks = 0;
   int n_fail = 0;
   logic [63:0] ref_mem [0:1][0:DEPTH-1];

   scan_engine_if #(.DW(DW), .AW(AW)) bus0 ();
   scan_engine_if #(.DW(DW), .AW(AW)) bus1 ();

   assign bus0.r_enable = r_enable;           assign bus1.r_enable = r_enable;
   assign bus0.init_i = init_i;               assign bus1.init_i = init_i;
   assign bus0.init_len = init_len;           assign bus1.init_len = init_len;
   assign bus0.init_acc = init_acc;           assign bus1.init_acc = init_acc;
   assign bus0.mode = mode;                   assign bus1.mode = mode;
   assign bus0.controlArr = host_en;          assign bus1.controlArr = host_en;
   assign bus0.controlArrWEnable = host_we;   assign bus1.controlArrWEnable = host_we;
   assign bus0.controlArrAddr = host_addr;    assign bus1.controlArrAddr = host_addr;
   assign bus0.controlArrWData = host_wdata;  assign bus1.controlArrWData = host_wdata;

   scan_engine #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .SAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   scan_engine #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .SAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   always #5 clk = ~clk;

   typedef struct packed {
      int               i;
      int               len;
      logic [63:0]      acc;
      logic [1:0]       md;
      int               np;
      logic [0:3][63:0] pre;
      logic [63:0]      res0;
      logic [63:0]      res1;
      logic             tr;
      int               lat;
      logic [0:3][63:0] arr0;
      logic [0:3][63:0] arr1;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic logic [63:0] m_add(input logic signed [63:0] a, input logic signed [63:0] b, input int sat);
      logic signed [64:0] s;
      s = a;
      s = s + b;
      if (sat != 0 && s > MAXV) return 64'h7FFF_FFFF_FFFF_FFFF;
      if (sat != 0 && s < MINV) return 64'h8000_0000_0000_0000;
      return s[63:0];
   endfunction

   function automatic logic [63:0] rnd64();
      logic [63:0] v;
      case ($urandom_range(0, 3))
         0: v = 64'(longint'($urandom_range(0, 2000)) - 64'sd1000);
         1: v = 64'h7FFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
         2: v = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 255));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // Reference: processes up to 'limit' elements of the run on both model arrays.
   task automatic model_run(input int i, input int len, input logic [63:0] acc_in, input logic [1:0] md,
                            input int limit, output logic [63:0] r0, output logic [63:0] r1,
                            output logic tr, output int cnt);
      int avail;
      int n;
      logic signed [63:0] acc;
      logic signed [63:0] d;
      avail = (i >= DEPTH) ? 0 : DEPTH - i;
      cnt = (len < avail) ? len : avail;
      tr = (len > avail);
      n = (cnt < limit) ? cnt : limit;
      r0 = 64'd0;
      r1 = 64'd0;
      for (int s = 0; s < 2; s++) begin
         acc = acc_in;
         for (int k = 0; k < n; k++) begin
            d = ref_mem[s][i+k];
            case (md)
               2'd0: begin acc = m_add(acc, d, s); ref_mem[s][i+k] = acc; end
               2'd1: begin ref_mem[s][i+k] = acc; acc = m_add(acc, d, s); end
               2'd2: acc = m_add(acc, d, s);
               default: begin if (d > acc) acc = d; ref_mem[s][i+k] = acc; end
            endcase
         end
         if (s == 0) r0 = acc;
         else        r1 = acc;
      end
   endtask

   task automatic host_write(input int a, input logic [63:0] d);
      host_en = 1'b1; host_we = 1'b1; host_addr = AW'(a); host_wdata = d;
      @(posedge clk); #1;
      host_we = 1'b0;
      ref_mem[0][a] = d;
      ref_mem[1][a] = d;
   endtask

   task automatic host_read(input int a, output logic [63:0] d0, output logic [63:0] d1);
      host_en = 1'b1; host_we = 1'b0; host_addr = AW'(a);
      @(posedge clk); #1;
      d0 = bus0.controlArrRData;
      d1 = bus1.controlArrRData;
   endtask

   task automatic host_release();
      host_en = 1'b0;
      host_we = 1'b0;
   endtask

   task automatic readback_model(input string tag, input int i, input int n);
      logic [63:0] d0, d1;
      for (int k = 0; k < n; k++) begin
         if (i + k < DEPTH) begin
            host_read(i + k, d0, d1);
            chk($sformatf("%s a0[%0d]", tag, i + k), d0, ref_mem[0][i+k]);
            chk($sformatf("%s a1[%0d]", tag, i + k), d1, ref_mem[1][i+k]);
         end
      end
      host_release();
   endtask

   // Drive the start pulse; returns half a cycle after the sampling edge E0.
   task automatic start_op(input int i, input int len, input logic [63:0] acc, input logic [1:0] md);
      init_i = AW'(i); init_len = (AW+1)'(len); init_acc = acc; mode = md;
      r_enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      r_enable = 1'b0;
   endtask

   // Counts edges until either engine raises w_enable (bounded).
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!(bus0.w_enable || bus1.w_enable) && cyc < 2000);
   endtask

   task automatic check_done(input string tag, input int offs, input int exp_lat,
                             input logic [63:0] e0, input logic [63:0] e1, input logic etr);
      int cyc;
      wait_done(cyc);
      chk({tag, " done0"}, 64'(bus0.w_enable), 64'd1);
      chk({tag, " done1"}, 64'(bus1.w_enable), 64'd1);
      chk({tag, " latency"}, 64'(offs + cyc), 64'(exp_lat));
      chk({tag, " result0"}, bus0.result, e0);
      chk({tag, " result1"}, bus1.result, e1);
      chk({tag, " trunc0"}, 64'(bus0.trunc), 64'(etr));
      chk({tag, " trunc1"}, 64'(bus1.trunc), 64'(etr));
   endtask

   logic [63:0] e0, e1, d0, d1, ra;
   logic        etr;
   int          cnt, cyc, ri, rl;
   logic [1:0]  rm;

   initial begin
      vecs[0] = '{i:0, len:4, acc:64'd10, md:2'd0, np:4, pre:{64'd1, 64'd2, 64'd3, 64'd4},
                  res0:64'd20, res1:64'd20, tr:1'b0, lat:13,
                  arr0:{64'd11, 64'd13, 64'd16, 64'd20}, arr1:{64'd11, 64'd13, 64'd16, 64'd20}};
      vecs[1] = '{i:0, len:4, acc:64'd10, md:2'd1, np:4, pre:{64'd1, 64'd2, 64'd3, 64'd4},
                  res0:64'd20, res1:64'd20, tr:1'b0, lat:13,
                  arr0:{64'd10, 64'd11, 64'd13, 64'd16}, arr1:{64'd10, 64'd11, 64'd13, 64'd16}};
      vecs[2] = '{i:0, len:4, acc:64'd10, md:2'd2, np:4, pre:{64'd1, 64'd2, 64'd3, 64'd4},
                  res0:64'd20, res1:64'd20, tr:1'b0, lat:13,
                  arr0:{64'd1, 64'd2, 64'd3, 64'd4}, arr1:{64'd1, 64'd2, 64'd3, 64'd4}};
      vecs[3] = '{i:0, len:4, acc:64'd0, md:2'd3, np:4, pre:{64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd9, 64'd2},
                  res0:64'd9, res1:64'd9, tr:1'b0, lat:13,
                  arr0:{64'd5, 64'd5, 64'd9, 64'd9}, arr1:{64'd5, 64'd5, 64'd9, 64'd9}};
      vecs[4] = '{i:998, len:5, acc:64'd1, md:2'd0, np:2, pre:{64'd7, 64'd8, 64'd0, 64'd0},
                  res0:64'd16, res1:64'd16, tr:1'b1, lat:7,
                  arr0:{64'd8, 64'd16, 64'd0, 64'd0}, arr1:{64'd8, 64'd16, 64'd0, 64'd0}};
      vecs[5] = '{i:0, len:0, acc:64'd77, md:2'd0, np:0, pre:{64'd0, 64'd0, 64'd0, 64'd0},
                  res0:64'd77, res1:64'd77, tr:1'b0, lat:1,
                  arr0:{64'd0, 64'd0, 64'd0, 64'd0}, arr1:{64'd0, 64'd0, 64'd0, 64'd0}};
      vecs[6] = '{i:0, len:1, acc:64'h7FFF_FFFF_FFFF_FFFE, md:2'd0, np:1, pre:{64'd5, 64'd0, 64'd0, 64'd0},
                  res0:64'h8000_0000_0000_0003, res1:64'h7FFF_FFFF_FFFF_FFFF, tr:1'b0, lat:4,
                  arr0:{64'h8000_0000_0000_0003, 64'd0, 64'd0, 64'd0},
                  arr1:{64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0}};
      vecs[7] = '{i:1000, len:3, acc:64'd42, md:2'd0, np:0, pre:{64'd0, 64'd0, 64'd0, 64'd0},
                  res0:64'd42, res1:64'd42, tr:1'b1, lat:1,
                  arr0:{64'd0, 64'd0, 64'd0, 64'd0}, arr1:{64'd0, 64'd0, 64'd0, 64'd0}};
      vecs[8] = '{i:999, len:1, acc:64'hFFFF_FFFF_FFFF_FFFB, md:2'd1, np:1, pre:{64'd3, 64'd0, 64'd0, 64'd0},
                  res0:64'hFFFF_FFFF_FFFF_FFFE, res1:64'hFFFF_FFFF_FFFF_FFFE, tr:1'b0, lat:4,
                  arr0:{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0, 64'd0},
                  arr1:{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0, 64'd0}};

      rst_n = 1'b0; r_enable = 1'b0; init_i = '0; init_len = '0; init_acc = '0; mode = 2'd0;
      host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      repeat (2) @(negedge clk);
      chk("reset w_enable0", 64'(bus0.w_enable), 64'd0);
      chk("reset w_enable1", 64'(bus1.w_enable), 64'd0);
      chk("reset result0", bus0.result, 64'd0);
      chk("reset result1", bus1.result, 64'd0);
      chk("reset trunc0", 64'(bus0.trunc), 64'd0);
      chk("reset trunc1", 64'(bus1.trunc), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int a = 0; a < DEPTH; a++) host_write(a, rnd64());
      host_release();

      // Directed table
      for (int v = 0; v < 9; v++) begin
         for (int k = 0; k < vecs[v].np; k++) host_write(vecs[v].i + k, vecs[v].pre[k]);
         host_release();
         model_run(vecs[v].i, vecs[v].len, vecs[v].acc, vecs[v].md, BIG, e0, e1, etr, cnt);
         start_op(vecs[v].i, vecs[v].len, vecs[v].acc, vecs[v].md);
         check_done($sformatf("vec%0d", v), 0, vecs[v].lat, vecs[v].res0, vecs[v].res1, vecs[v].tr);
         for (int k = 0; k < vecs[v].np; k++) begin
            host_read(vecs[v].i + k, d0, d1);
            chk($sformatf("vec%0d arr0[%0d]", v, k), d0, vecs[v].arr0[k]);
            chk($sformatf("vec%0d arr1[%0d]", v, k), d1, vecs[v].arr1[k]);
         end
         host_release();
      end

      // Host takes the array for 7 cycles while the first element is in ACC
      for (int k = 0; k < 4; k++) host_write(k, 64'(k + 1));
      host_release();
      model_run(0, 4, 64'd10, 2'd0, BIG, e0, e1, etr, cnt);
      start_op(0, 4, 64'd10, 2'd0);
      @(negedge clk);
      host_en = 1'b1; host_we = 1'b0; host_addr = AW'(500);
      @(posedge clk); #1;
      chk("stall host read0", bus0.controlArrRData, ref_mem[0][500]);
      chk("stall host read1", bus1.controlArrRData, ref_mem[1][500]);
      repeat (7) @(negedge clk);
      host_en = 1'b0;
      wait_done(cyc);
      chk("stall done0", 64'(bus0.w_enable), 64'd1);
      chk_range("stall latency", 8 + cyc, 20, 21);
      chk("stall result0", bus0.result, 64'd20);
      chk("stall result1", bus1.result, 64'd20);
      readback_model("stall", 0, 4);
      chk("stall a[3]", ref_mem[0][3], 64'd20);

      // Restart at E0+8: two elements of the first run are already written
      ra = rnd64();
      model_run(0, 10, ra, 2'd0, 2, e0, e1, etr, cnt);
      start_op(0, 10, ra, 2'd0);
      repeat (7) @(negedge clk);
      chk("restart busy0", 64'(bus0.w_enable), 64'd0);
      chk("restart busy1", 64'(bus1.w_enable), 64'd0);
      model_run(20, 3, 64'h55, 2'd1, BIG, e0, e1, etr, cnt);
      start_op(20, 3, 64'h55, 2'd1);
      check_done("restart", 0, 10, e0, e1, etr);
      readback_model("restart", 0, 10);
      readback_model("restart", 20, 3);

      // Asynchronous reset in the middle of a run, after one element
      ra = rnd64();
      model_run(0, 6, ra, 2'd3, 1, e0, e1, etr, cnt);
      start_op(0, 6, ra, 2'd3);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset w_enable0", 64'(bus0.w_enable), 64'd0);
      chk("midreset w_enable1", 64'(bus1.w_enable), 64'd0);
      chk("midreset result0", bus0.result, 64'd0);
      chk("midreset result1", bus1.result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      readback_model("midreset", 0, 6);

      // Randomized runs against the model
      for (int t = 0; t < 25; t++) begin
         case ($urandom_range(0, 3))
            0, 1: ri = $urandom_range(0, 40);
            2: ri = $urandom_range(985, 999);
            default: ri = $urandom_range(1000, 1023);
         endcase
         rl = $urandom_range(0, 14);
         rm = 2'($urandom_range(0, 3));
         ra = rnd64();
         model_run(ri, rl, ra, rm, BIG, e0, e1, etr, cnt);
         start_op(ri, rl, ra, rm);
         check_done($sformatf("rnd%0d", t), 0, 3 * cnt + 1, e0, e1, etr);
         readback_model($sformatf("rnd%0d", t), ri, cnt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
